// File: rtl/edge_debounce_counter.sv
// edge_debounce_counter
//   Synchronises a raw level from an upstream flop, debounces it with a
//   four-state FSM, emits one-cycle rise/fall strobes on committed edges and
//   counts committed rising edges with a sticky overflow flag.
//
//   Build option EDGE_COUNT_SATURATE_EN:
//     defined   -> count holds at its maximum when a rise would overflow it
//     undefined -> count wraps to zero when a rise overflows it
//   The overflow flag sets identically in both builds.
module edge_debounce_counter #(
  parameter int SYNC_STAGES     = 2,  // synchroniser depth, >= 2
  parameter int DEBOUNCE_CYCLES = 4,  // agreeing samples to commit a level, >= 2
  parameter int COUNT_WIDTH     = 8   // width of the rise-event counter
) (
  input  logic                   clk,
  input  logic                   reset,      // asynchronous, active-low
  input  logic                   d_in,
  input  logic                   clr_count,
  output logic                   level,
  output logic                   rise,
  output logic                   fall,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_out;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   overflow_q, overflow_d;

  logic [COUNT_WIDTH-1:0] count_base;
  logic                   overflow_base;

  // Shift the raw input through the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Debounce FSM next state: a level commits only after DEBOUNCE_CYCLES
  // consecutive agreeing samples; any disagreement drops back silently.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (sync_out) begin
          state_d = PEND_HI;
          cnt_d   = CNT_ONE;
        end
      end
      PEND_HI: begin
        if (!sync_out) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!sync_out) begin
          state_d = PEND_LO;
          cnt_d   = CNT_ONE;
        end
      end
      PEND_LO: begin
        if (sync_out) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Rise counter: a clear applies first, so a coincident rise lands on zero.
  always_comb begin
    count_base    = clr_count ? '0   : count_q;
    overflow_base = clr_count ? 1'b0 : overflow_q;
    count_d       = count_base;
    overflow_d    = overflow_base;
    if (rise_d) begin
      if (count_base == COUNT_MAX) begin
        overflow_d = 1'b1;
`ifdef EDGE_COUNT_SATURATE_EN
        count_d    = COUNT_MAX;
`else
        count_d    = '0;
`endif
      end else begin
        count_d = count_base + 1'b1;
      end
    end
  end

  // All state registers; reset clears everything immediately, mid-debounce too.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '0;
      state_q    <= STABLE_LO;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // blocking here would let the synchroniser collapse into one stage.
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign level    = level_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_edge_debounce_counter.sv
// Directed bench for edge_debounce_counter with default parameters.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too,
// so after k calls to tick() the outputs reflect edge k.
module tb_edge_debounce_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       d_in = 1'b1;
  logic       clr_count = 1'b0;
  logic       level, rise, fall, overflow;
  logic [7:0] count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       d_in;
    logic       clr;
    logic       level;
    logic       rise;
    logic       fall;
    logic [7:0] count;
  } vec_t;

  vec_t vecs[$];

  edge_debounce_counter dut (
    .clk       (clk),
    .reset     (reset),
    .d_in      (d_in),
    .clr_count (clr_count),
    .level     (level),
    .rise      (rise),
    .fall      (fall),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input logic l, input logic r,
                           input logic f, input logic [7:0] c, input logic o);
    check({name, ".level"},    {31'd0, level},    {31'd0, l});
    check({name, ".rise"},     {31'd0, rise},     {31'd0, r});
    check({name, ".fall"},     {31'd0, fall},     {31'd0, f});
    check({name, ".count"},    {24'd0, count},    {24'd0, c});
    check({name, ".overflow"}, {31'd0, overflow}, {31'd0, o});
  endtask

  task automatic do_reset();
    reset = 1'b0;
    d_in = 1'b0;
    clr_count = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // One full debounced high pulse: rise commits on edge 6, fall on edge 6 of the low half.
  task automatic pulse();
    d_in = 1'b1;
    repeat (8) tick();
    d_in = 1'b0;
    repeat (8) tick();
  endtask

  function automatic void add(input logic d, input logic c, input logic l,
                              input logic r, input logic f, input logic [7:0] cnt);
    vec_t v;
    v.d_in = d; v.clr = c; v.level = l; v.rise = r; v.fall = f; v.count = cnt;
    vecs.push_back(v);
  endfunction

  initial begin
    // Rise then fall from a clean STABLE_LO, then a plain clear.
    //   d  clr lvl rise fall count
    add(1, 0,  0,  0,   0,   0);  // edge 1
    add(1, 0,  0,  0,   0,   0);
    add(1, 0,  0,  0,   0,   0);
    add(1, 0,  0,  0,   0,   0);
    add(1, 0,  0,  0,   0,   0);  // edge 5
    add(1, 0,  1,  1,   0,   1);  // edge 6: commit high
    add(1, 0,  1,  0,   0,   1);  // strobe lasts one cycle
    add(1, 0,  1,  0,   0,   1);
    add(0, 0,  1,  0,   0,   1);  // edge 1 of the fall
    add(0, 0,  1,  0,   0,   1);
    add(0, 0,  1,  0,   0,   1);
    add(0, 0,  1,  0,   0,   1);
    add(0, 0,  1,  0,   0,   1);  // edge 5
    add(0, 0,  0,  0,   1,   1);  // edge 6: commit low
    add(0, 0,  0,  0,   0,   1);
    add(0, 1,  0,  0,   0,   0);  // clear
    add(0, 0,  0,  0,   0,   0);

    // 1: reset held with d_in=1 -> everything stays 0.
    reset = 1'b0;
    d_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all($sformatf("reset_hold%0d", i), 0, 0, 0, 8'd0, 0);
    end
    reset = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check_all($sformatf("post_reset_e%0d", e), e == 6, e == 6, 0, (e == 6) ? 8'd1 : 8'd0, 0);
    end
    tick();
    check_all("post_reset_after", 1, 0, 0, 8'd1, 0);

    // 2: three-sample glitch from STABLE_LO produces nothing.
    do_reset();
    d_in = 1'b1;
    repeat (3) tick();
    d_in = 1'b0;
    for (int e = 4; e <= 12; e++) begin
      tick();
      check_all($sformatf("glitch_e%0d", e), 0, 0, 0, 8'd0, 0);
    end

    // 3: table-driven rise/fall sequence.
    do_reset();
    foreach (vecs[i]) begin
      d_in = vecs[i].d_in;
      clr_count = vecs[i].clr;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].level, vecs[i].rise, vecs[i].fall,
                vecs[i].count, 1'b0);
      check($sformatf("vec%0d.exclusive", i), {31'd0, rise & fall}, 32'd0);
    end
    clr_count = 1'b0;

    // 4: overflow on the 256th rise.
    do_reset();
    repeat (255) pulse();
    check_all("pre_overflow", 0, 0, 0, 8'd255, 0);
    pulse();
`ifdef EDGE_COUNT_SATURATE_EN
    check_all("overflow", 0, 0, 0, 8'd255, 1);
    pulse();
    check_all("overflow_sticky", 0, 0, 0, 8'd255, 1);
`else
    check_all("overflow", 0, 0, 0, 8'd0, 1);
    pulse();
    check_all("overflow_sticky", 0, 0, 0, 8'd1, 1);
`endif
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check_all("overflow_clear", 0, 0, 0, 8'd0, 0);

    // 5: clear coincident with a rise at count=7 -> count=1.
    repeat (7) pulse();
    check_all("count7", 0, 0, 0, 8'd7, 0);
    d_in = 1'b1;
    repeat (5) tick();
    check_all("clr_rise_pre", 0, 0, 0, 8'd7, 0);
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check_all("clr_rise", 1, 1, 0, 8'd1, 0);

    // Asynchronous reset mid-cycle clears the outputs without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 0, 8'd0, 0);
    tick();
    reset = 1'b1;

    // 6: reset in PEND_HI with cnt=2, then full latency after release.
    do_reset();
    d_in = 1'b1;
    repeat (4) tick();
    #2;
    reset = 1'b0;
    #1;
    check_all("pend_reset", 0, 0, 0, 8'd0, 0);
    tick();
    check_all("pend_reset_hold", 0, 0, 0, 8'd0, 0);
    tick();
    reset = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check_all($sformatf("pend_release_e%0d", e), e == 6, e == 6, 0,
                (e == 6) ? 8'd1 : 8'd0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
